// File: rtl/layer_act_streamer.sv
// layer_act_streamer: captures one layer's parallel activation vector in a
// single handshake, then streams it word-by-word (data, index, last) over a
// valid/ready link.
// Optional feature macro: ACT_STREAM_ZERO_SKIP_EN. When it is defined, zero
// words are skipped. The final element is always emitted so the frame has a
// terminating beat.
module layer_act_streamer #(
  parameter int N_ACT = 30,
  parameter int DW    = 16,
  parameter int IDX_W = 5,
  parameter int FC_W  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N_ACT*DW-1:0]   in_vec,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DW-1:0]         out_data,
  output logic [IDX_W-1:0]      out_idx,
  output logic                  out_last,
  output logic                  busy,
  output logic [FC_W-1:0]       frame_cnt
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ACT - 1);

  typedef enum logic {IDLE, STREAM} state_t;
  state_t state, state_nxt;

  logic [N_ACT-1:0][DW-1:0] bank;
  logic [N_ACT-1:0][DW-1:0] in_words;
  logic [IDX_W-1:0]         first_idx, next_idx;
  logic                     cap, fire, done;

  // word view of the flat input bus (element k at bits [k*DW +: DW])
  assign in_words = in_vec;

  assign cap  = (state == IDLE) && in_valid;
  assign fire = (state == STREAM) && out_ready;
  assign done = fire && out_last;

`ifdef ACT_STREAM_ZERO_SKIP_EN
  logic [N_ACT-1:0] mask, cap_mask;

  // nonzero mask of the incoming vector; last element forced so every frame terminates
  always_comb begin
    cap_mask = '0;
    for (int k = 0; k < N_ACT; k++) cap_mask[k] = (in_words[k] != '0);
    cap_mask[N_ACT-1] = 1'b1;
  end

  // lowest set bit of the capture mask is the first element to emit
  always_comb begin
    first_idx = LAST_IDX;
    for (int k = N_ACT - 1; k >= 0; k--)
      if (cap_mask[k]) first_idx = IDX_W'(k);
  end

  // next set mask bit strictly above the current index
  always_comb begin
    next_idx = LAST_IDX;
    for (int k = N_ACT - 1; k >= 0; k--)
      if (mask[k] && (IDX_W'(k) > out_idx)) next_idx = IDX_W'(k);
  end

  // mask lives alongside the bank for the duration of the stream
  always_ff @(posedge clk) begin
    if (reset)    mask <= '0;
    else if (cap) mask <= cap_mask;
  end
`else
  assign first_idx = '0;
  assign next_idx  = out_idx + IDX_W'(1);
`endif

  // capture bank and registered output word; held while the consumer stalls
  always_ff @(posedge clk) begin
    if (reset) begin
      bank     <= '0;
      out_data <= '0;
      out_idx  <= '0;
      out_last <= 1'b0;
    end else if (cap) begin
      bank     <= in_words;
      out_data <= in_words[first_idx];
      out_idx  <= first_idx;
      out_last <= (first_idx == LAST_IDX);
    end else if (fire && !out_last) begin
      out_data <= bank[next_idx];
      out_idx  <= next_idx;
      out_last <= (next_idx == LAST_IDX);
    end
  end

  // completed-frame counter, wraps naturally
  always_ff @(posedge clk) begin
    if (reset)     frame_cnt <= '0;
    else if (done) frame_cnt <= frame_cnt + FC_W'(1);
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // next-state: capture starts a stream, accepted last beat ends it
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = STREAM;
      STREAM:  if (done)     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // handshake/status outputs decoded from state only
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == STREAM);
    busy      = (state == STREAM);
  end

endmodule

// File: tb/tb_layer_act_streamer.sv
// Bench for layer_act_streamer: table-driven vectors plus randomized vectors
// against a queue-based model of the emitted beat sequence.
module tb_layer_act_streamer;
  localparam int N  = 30;
  localparam int DW = 16;
  localparam int IW = 5;
  localparam int FW = 8;
  localparam int VW = N * DW;

  logic          clk = 1'b0;
  logic          reset, in_valid, out_ready;
  logic          in_ready, out_valid, out_last, busy;
  logic [VW-1:0] in_vec;
  logic [DW-1:0] out_data;
  logic [IW-1:0] out_idx;
  logic [FW-1:0] frame_cnt;

  layer_act_streamer #(.N_ACT(N), .DW(DW), .IDX_W(IW), .FC_W(FW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
    .busy(busy), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int exp_fc = 0;
  int exp_q[$];

  typedef struct {
    logic [VW-1:0] vec;
    int            mode;      // 0 ready high, 1 pattern 1,0,0, 2 random
    bit            hold_busy; // keep a second vector on in_valid during the stream
    int            exp_beats;
    int            exp_first;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] word(input logic [VW-1:0] v, input int k);
    return v[k*DW +: DW];
  endfunction

  // model: which element indices a vector produces, in order
  task automatic build_exp(input logic [VW-1:0] v);
    exp_q.delete();
    for (int k = 0; k < N; k++) begin
`ifdef ACT_STREAM_ZERO_SKIP_EN
      if (word(v, k) != 0 || k == N - 1) exp_q.push_back(k);
`else
      exp_q.push_back(k);
`endif
    end
  endtask

  // called at a negedge with the DUT idle; returns at a negedge after the frame
  task automatic stream_vec(input logic [VW-1:0] v, input int mode, input bit hold_busy,
                            output int nbeats, output int first_idx);
    int ptr, cyc;
    bit stalled, done, pv, pl;
    logic [IW-1:0] pidx;
    logic [DW-1:0] pdata;
    logic [VW-1:0] busy_vec;
    build_exp(v);
    nbeats = 0; first_idx = -1; ptr = 0; cyc = 0; stalled = 0; done = 0;
    for (int k = 0; k < N; k++) busy_vec[k*DW +: DW] = 16'h7FFF;
    check("in_ready_before_capture", in_ready, 1);
    in_valid = 1'b1; in_vec = v; out_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    if (hold_busy) in_vec = busy_vec;
    else in_valid = 1'b0;
    while (!done) begin
      if (cyc > 4 * N + 20) begin
        n_cmp++; n_err++;
        $display("FAIL stream_timeout: got %0d beats expected %0d", nbeats, exp_q.size());
        break;
      end
      check("busy_stream", busy, 1);
      check("in_ready_stream", in_ready, 0);
      check("out_valid_stream", out_valid, 1);
      if (cyc == 0) first_idx = int'(out_idx);
      if (stalled) begin
        check("stall_idx_stable", out_idx, pidx);
        check("stall_data_stable", out_data, pdata);
      end
      if (ptr < exp_q.size()) begin
        check("beat_idx", out_idx, exp_q[ptr]);
        check("beat_data", out_data, word(v, exp_q[ptr]));
        check("beat_last", out_last, (ptr == exp_q.size() - 1));
      end else begin
        n_cmp++; n_err++;
        $display("FAIL extra_beat: got idx %0d expected no beat", out_idx);
      end
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 3 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      pidx = out_idx; pdata = out_data; pv = out_valid; pl = out_last;
      stalled = pv && !out_ready;
      @(posedge clk);
      if (pv && out_ready) begin
        nbeats++; ptr++;
        if (pl) done = 1;
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    check("beat_count", nbeats, exp_q.size());
    if (done) begin
      exp_fc = (exp_fc + 1) % (1 << FW);
      check("out_valid_after_last", out_valid, 0);
      check("in_ready_after_last", in_ready, 1);
      check("busy_after_last", busy, 0);
      check("frame_cnt", frame_cnt, exp_fc);
    end
  endtask

  initial begin
    vec_t tbl[6];
    logic [VW-1:0] ramp, v;
    int nb, fi, guard;

    for (int k = 0; k < N; k++) ramp[k*DW +: DW] = 16'h0100 + 16'(k);

    tbl[0].vec = ramp; tbl[0].mode = 0; tbl[0].hold_busy = 1;
    tbl[0].exp_beats = 30; tbl[0].exp_first = 0;
    for (int k = 0; k < N; k++) v[k*DW +: DW] = 16'h7FFF;
    tbl[1].vec = v; tbl[1].mode = 0; tbl[1].hold_busy = 0;
    tbl[1].exp_beats = 30; tbl[1].exp_first = 0;
    tbl[2].vec = ramp; tbl[2].mode = 1; tbl[2].hold_busy = 0;
    tbl[2].exp_beats = 30; tbl[2].exp_first = 0;
    v = '0; v[3*DW +: DW] = 16'h0042; v[17*DW +: DW] = 16'h0005;
    tbl[3].vec = v; tbl[3].mode = 0; tbl[3].hold_busy = 0;
    tbl[4].vec = '0; tbl[4].mode = 2; tbl[4].hold_busy = 0;
`ifdef ACT_STREAM_ZERO_SKIP_EN
    tbl[3].exp_beats = 3;  tbl[3].exp_first = 3;
    tbl[4].exp_beats = 1;  tbl[4].exp_first = 29;
`else
    tbl[3].exp_beats = 30; tbl[3].exp_first = 0;
    tbl[4].exp_beats = 30; tbl[4].exp_first = 0;
`endif
    for (int k = 0; k < N; k++) v[k*DW +: DW] = 16'h8000 | 16'(k * 7);
    tbl[5].vec = v; tbl[5].mode = 2; tbl[5].hold_busy = 0;
    tbl[5].exp_beats = 30; tbl[5].exp_first = 0;

    // reset, then idle must hold
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_vec = '0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_frame_cnt", frame_cnt, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_idx", out_idx, 0);
      check("rst_out_last", out_last, 0);
      @(negedge clk);
    end

    // table vectors (entry 0 holds a busy vector that entry 1 then captures)
    for (int i = 0; i < 6; i++) begin
      stream_vec(tbl[i].vec, tbl[i].mode, tbl[i].hold_busy, nb, fi);
      check("tbl_beats", nb, tbl[i].exp_beats);
      check("tbl_first_idx", fi, tbl[i].exp_first);
    end

    // reset while beat idx 10 is presented
    in_valid = 1'b1; in_vec = ramp; out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    guard = 0;
    while (out_idx != 5'd10 && guard < 4 * N) begin
      @(negedge clk); guard++;
    end
    check("reach_idx10", out_idx, 10);
    reset = 1'b1; out_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    exp_fc = 0;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_frame_cnt", frame_cnt, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_in_ready", in_ready, 1);
    @(negedge clk);
    check("midrst_still_idle", out_valid, 0);
    stream_vec(ramp, 0, 0, nb, fi);
    check("after_rst_first_idx", fi, 0);

    // randomized vectors; enough frames to wrap frame_cnt
    for (int i = 0; i < 270; i++) begin
      for (int k = 0; k < N; k++)
        v[k*DW +: DW] = ($urandom_range(0, 1) == 0) ? 16'h0000 : 16'($urandom);
      if (i % 17 == 0) v = '0;
      stream_vec(v, int'($urandom_range(0, 2)), 0, nb, fi);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
